uibi_master_port: RTL and testbench
===================================

# uibi_master_port

Initiator end of the unisys internal bus (UIBI). Turns a core-side load/store request (byte/half/word, signed/unsigned) into a single UIBI master transaction. It splits the address into `bus_num` and `bus_addr`, encodes `bus_mode`, lane-aligns write data, holds `bus_req` until `bus_ready`, then right-aligns and extends read data. It sits between a CPU/DMA load-store stage and one master slot of the bus crossbar, and enforces alignment and an optional response timeout.

## Interface
Clock and reset: one clock; reset is synchronous and active-low.

Parameters:
- `XLEN`, 32: data/address width; only 32 is supported.
- `SLAVE_WIDTH`, 4: number of upper address bits used as slave number.
- `TIMEOUT`, 256: maximum number of cycles to wait for `bus_ready`; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset.
- `cpu_req`  in  1  request valid.
- `cpu_ready`  out  1  request accepted in a cycle with `cpu_req && cpu_ready`.
- `cpu_wen`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  XLEN  byte address.
- `cpu_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal (treated as misaligned).
- `cpu_unsigned`  in  1  zero-extend load data when 1, sign-extend when 0.
- `cpu_wdata`  in  XLEN  store data, right-aligned.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  valid with `cpu_done`: misaligned access or timeout.
- `cpu_rdata`  out  XLEN  extended load data, valid with `cpu_done`.
- `bus_dat_i`  in  XLEN  read data returned by the slave.
- `bus_dat_o`  out  XLEN  lane-aligned write data.
- `bus_addr`  out  XLEN-SLAVE_WIDTH  `cpu_addr[XLEN-SLAVE_WIDTH-1:0]`.
- `bus_num`  out  SLAVE_WIDTH  `cpu_addr[XLEN-1:XLEN-SLAVE_WIDTH]`.
- `bus_req`, `bus_wen`  out  1  bus request and write enable.
- `bus_mode`  out  3  `111` = word, `011` = half, `001` = byte.
- `bus_ready`  in  1  slave completion.

## Operation
- FSM states: IDLE, BUS, RESP.
  - IDLE: `cpu_ready = 1` (0 while `rst_n` is low).
- On accept:
  - Register `wen`, size, unsigned, `off = cpu_addr[1:0]`, address split, `bus_mode`, and `bus_dat_o = cpu_wdata << (8*off)`.
  - A misaligned request (half with `off[0] = 1`, word with `off != 0`, or size 3) goes to RESP with `cpu_err = 1` and issues no bus access.
  - Any other request goes to BUS.
- BUS:
  - `bus_req = 1`; `bus_addr`, `bus_num`, `bus_wen`, `bus_mode` and `bus_dat_o` are stable.
  - When `bus_ready` is sampled high: for a load, capture `bus_dat_i >> (8*off)`, truncated to the size and extended per `cpu_unsigned`; for a store, `cpu_rdata = 0`. Then go to RESP.
  - Timeout counter: cleared on entry, increments each BUS cycle. If it reaches `TIMEOUT` (when `TIMEOUT != 0`) with no `bus_ready`, go to RESP with `cpu_err = 1` and `cpu_rdata = 0`.
- RESP: `cpu_done = 1` for exactly one cycle, `cpu_ready = 0`, `bus_req = 0`; then go to IDLE.
- `bus_ready` while `bus_req = 0` is ignored.
- A `cpu_req` arriving outside IDLE is not accepted and is not queued.
- Reset mid-operation: all registers return to reset values at the next edge. `bus_req` drops and no `cpu_done` is produced.

## Timing
- Reset values:
  - State IDLE.
  - `bus_req`, `bus_wen`, `cpu_done`, `cpu_err` are 0.
  - `bus_mode = 000`.
  - `bus_addr`, `bus_num`, `bus_dat_o`, `cpu_rdata` are 0.
- All bus outputs are registered; there is no combinational path from `cpu_*` to `bus_*`.
- Latency, with accept at cycle 0:
  - `bus_req` rises at cycle 1.
  - If `bus_ready` arrives at cycle k ≥ 1, `bus_req` falls and `cpu_done` pulses at cycle k+1.
  - The next accept is possible at cycle k+2.
- Misaligned request: `cpu_done` and `cpu_err` pulse at cycle 1; `bus_req` never rises.
- Timeout: `bus_req` is high for `TIMEOUT` cycles, then `cpu_done` and `cpu_err` pulse.
- Outputs `bus_addr`, `bus_num`, `bus_wen`, `bus_mode`, `bus_dat_o` keep the last transaction's values after completion.

## Structure
- Package `uibi_pkg`:
  - `size_t` enum (BYTE, HALF, WORD).
  - Mode constants `UIBI_MODE_WORD`, `UIBI_MODE_HALF`, `UIBI_MODE_BYTE`.
  - `fsm_t` (IDLE, BUS, RESP).
  - Function `uibi_misaligned(size, off)`.
- Sub-module `uibi_lane_align` (combinational):
  - Write path: `wdata` and `off` in, lane-shifted data out.
  - Read path: `bus_dat_i`, `off`, size and unsigned in, extended `rdata` out.
- The FSM, timeout counter and output registers live in `uibi_master_port`.

## Test plan
- Byte store: `cpu_addr = 0x3000_0006`, `cpu_wdata = 0xAB`. Require `bus_num = 0x3`, `bus_addr = 0x000_0006`, `bus_mode = 001`, `bus_dat_o = 0x00AB_0000`, `bus_wen = 1`. With `bus_ready` at cycle 3, `cpu_done` pulses at cycle 4 with `cpu_err = 0`.
- Signed half load: `cpu_addr = 0x1000_0002`, `bus_dat_i = 0x8001_1234`. Require `cpu_rdata = 0xFFFF_8001`. The same access with `cpu_unsigned = 1` returns `0x0000_8001`.
- Misaligned word at `0x1000_0001`: require `bus_req` to stay 0, and `cpu_done = cpu_err = 1` at cycle 1.
- `TIMEOUT = 4` with `bus_ready` held 0: require `bus_req` high for 4 cycles, then `cpu_err = 1` and `cpu_rdata = 0`.
- Back-to-back: `cpu_req` held high with `bus_ready` tied to 1. Require accepts every 3 cycles and `cpu_ready = 0` during BUS and RESP.
- Reset asserted during BUS: require `bus_req = 0` next cycle, no `cpu_done`, and all outputs at reset values.

Source files
------------

// File: rtl/uibi_pkg.sv
// uibi_pkg: shared types, bus mode encodings and alignment helper for the UIBI master port
package uibi_pkg;

    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} size_t;

    localparam logic [2:0] UIBI_MODE_WORD = 3'b111;
    localparam logic [2:0] UIBI_MODE_HALF = 3'b011;
    localparam logic [2:0] UIBI_MODE_BYTE = 3'b001;

    typedef logic [1:0] fsm_t;
    localparam fsm_t IDLE = 2'd0;
    localparam fsm_t BUS  = 2'd1;
    localparam fsm_t RESP = 2'd2;

    // Size code 3 has no legal encoding, so it is rejected like a misaligned access
    function automatic logic uibi_misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == 2'd3 || (size == HALF && off[0]) || (size == WORD && off != 2'd0);
    endfunction

endpackage

// File: rtl/uibi_lane_align.sv
// uibi_lane_align: write-lane shift and read right-align/extend for the UIBI master port
module uibi_lane_align #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      wr_off,
    output logic [XLEN-1:0] wdata_sh,
    input  logic [XLEN-1:0] bus_dat_i,
    input  logic [1:0]      rd_off,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] rdata
);
    import uibi_pkg::*;

    logic [XLEN-1:0] sh;

    assign wdata_sh = wdata << {wr_off, 3'b000};
    assign sh       = bus_dat_i >> {rd_off, 3'b000};
    assign rdata    = size == BYTE ? {{(XLEN-8){!is_unsigned && sh[7]}}, sh[7:0]} :
                      size == HALF ? {{(XLEN-16){!is_unsigned && sh[15]}}, sh[15:0]} : sh;

endmodule

// File: rtl/uibi_master_port.sv
// uibi_master_port: turns one core load/store into a single registered UIBI master transaction
module uibi_master_port #(
    parameter int XLEN        = 32,
    parameter int SLAVE_WIDTH = 4,
    parameter int TIMEOUT     = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req,
    output logic                    cpu_ready,
    input  logic                    cpu_wen,
    input  logic [XLEN-1:0]         cpu_addr,
    input  logic [1:0]              cpu_size,
    input  logic                    cpu_unsigned,
    input  logic [XLEN-1:0]         cpu_wdata,
    output logic                    cpu_done,
    output logic                    cpu_err,
    output logic [XLEN-1:0]         cpu_rdata,
    input  logic [XLEN-1:0]         bus_dat_i,
    output logic [XLEN-1:0]         bus_dat_o,
    output logic [XLEN-SLAVE_WIDTH-1:0] bus_addr,
    output logic [SLAVE_WIDTH-1:0]  bus_num,
    output logic                    bus_req,
    output logic                    bus_wen,
    output logic [2:0]              bus_mode,
    input  logic                    bus_ready
);
    import uibi_pkg::*;

    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    fsm_t            state;
    logic [1:0]      size_r;
    logic [1:0]      off_r;
    logic            uns_r;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] rd_ext;
    logic [2:0]      mode;
    logic            mis;

    assign cpu_ready = rst_n && state == IDLE;
    assign bus_req   = state == BUS;
    assign cpu_done  = state == RESP;
    assign mis       = uibi_misaligned(cpu_size, cpu_addr[1:0]);
    assign mode      = cpu_size == BYTE ? UIBI_MODE_BYTE :
                       cpu_size == HALF ? UIBI_MODE_HALF :
                       cpu_size == WORD ? UIBI_MODE_WORD : 3'b000;

    uibi_lane_align #(.XLEN(XLEN)) u_align (
        .wdata       (cpu_wdata),
        .wr_off      (cpu_addr[1:0]),
        .wdata_sh    (wdata_sh),
        .bus_dat_i   (bus_dat_i),
        .rd_off      (off_r),
        .size        (size_r),
        .is_unsigned (uns_r),
        .rdata       (rd_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            size_r    <= '0;
            off_r     <= '0;
            uns_r     <= 1'b0;
            cnt       <= '0;
            bus_wen   <= 1'b0;
            bus_mode  <= 3'b000;
            bus_addr  <= '0;
            bus_num   <= '0;
            bus_dat_o <= '0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
        end else if (state == IDLE) begin
            if (cpu_req) begin
                state     <= mis ? RESP : BUS;
                size_r    <= cpu_size;
                off_r     <= cpu_addr[1:0];
                uns_r     <= cpu_unsigned;
                cnt       <= '0;
                bus_wen   <= cpu_wen;
                bus_mode  <= mode;
                bus_addr  <= cpu_addr[XLEN-SLAVE_WIDTH-1:0];
                bus_num   <= cpu_addr[XLEN-1:XLEN-SLAVE_WIDTH];
                bus_dat_o <= wdata_sh;
                cpu_err   <= mis;
                cpu_rdata <= mis ? '0 : cpu_rdata;
            end
        end else if (state == BUS) begin
            if (bus_ready) begin
                state     <= RESP;
                cpu_rdata <= bus_wen ? '0 : rd_ext;
            end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                state     <= RESP;
                cpu_err   <= 1'b1;
                cpu_rdata <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_uibi_master_port.sv
// tb_uibi_master_port: directed vectors with hand-computed expectations for uibi_master_port
module tb_uibi_master_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_ready;
    logic        cpu_wen;
    logic [31:0] cpu_addr;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned;
    logic [31:0] cpu_wdata;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic [31:0] bus_dat_i;
    logic [31:0] bus_dat_o;
    logic [27:0] bus_addr;
    logic [3:0]  bus_num;
    logic        bus_req;
    logic        bus_wen;
    logic [2:0]  bus_mode;
    logic        bus_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uibi_master_port #(.XLEN(32), .SLAVE_WIDTH(4), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_ready    (cpu_ready),
        .cpu_wen      (cpu_wen),
        .cpu_addr     (cpu_addr),
        .cpu_size     (cpu_size),
        .cpu_unsigned (cpu_unsigned),
        .cpu_wdata    (cpu_wdata),
        .cpu_done     (cpu_done),
        .cpu_err      (cpu_err),
        .cpu_rdata    (cpu_rdata),
        .bus_dat_i    (bus_dat_i),
        .bus_dat_o    (bus_dat_o),
        .bus_addr     (bus_addr),
        .bus_num      (bus_num),
        .bus_req      (bus_req),
        .bus_wen      (bus_wen),
        .bus_mode     (bus_mode),
        .bus_ready    (bus_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        cpu_req      = 1'b1;
        cpu_wen      = wen;
        cpu_addr     = addr;
        cpu_size     = size;
        cpu_unsigned = uns;
        cpu_wdata    = wdata;
    endtask

    // Load with bus_ready at cycle 1, leaving the sim at the cycle-2 completion
    task automatic load1(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] data);
        issue(1'b0, addr, size, uns, 32'h0);
        step();
        cpu_req   = 1'b0;
        bus_ready = 1'b1;
        bus_dat_i = data;
        step();
        bus_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_size = 2'd0;
        cpu_unsigned = 1'b0; cpu_wdata = '0; bus_dat_i = '0; bus_ready = 1'b0;
        step();
        step();
        check("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        check("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("rst_bus_mode", {29'b0, bus_mode}, 32'd0);
        check("rst_cpu_done", {31'b0, cpu_done}, 32'd0);
        check("rst_bus_dat_o", bus_dat_o, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_cpu_ready", {31'b0, cpu_ready}, 32'd1);

        // Byte store, bus_ready at cycle 3
        issue(1'b1, 32'h3000_0006, 2'd0, 1'b0, 32'h0000_00AB);
        step();
        cpu_req = 1'b0;
        check("bs_bus_req", {31'b0, bus_req}, 32'd1);
        check("bs_bus_num", {28'b0, bus_num}, 32'h3);
        check("bs_bus_addr", {4'b0, bus_addr}, 32'h0000_0006);
        check("bs_bus_mode", {29'b0, bus_mode}, 32'b001);
        check("bs_bus_dat_o", bus_dat_o, 32'h00AB_0000);
        check("bs_bus_wen", {31'b0, bus_wen}, 32'd1);
        check("bs_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        step();
        check("bs_req_c2", {31'b0, bus_req}, 32'd1);
        step();
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        check("bs_done", {31'b0, cpu_done}, 32'd1);
        check("bs_err", {31'b0, cpu_err}, 32'd0);
        check("bs_req_low", {31'b0, bus_req}, 32'd0);
        check("bs_rdata", cpu_rdata, 32'd0);
        check("bs_resp_ready", {31'b0, cpu_ready}, 32'd0);
        step();
        check("bs_done_pulse", {31'b0, cpu_done}, 32'd0);
        check("bs_addr_hold", {4'b0, bus_addr}, 32'h0000_0006);
        check("bs_dat_hold", bus_dat_o, 32'h00AB_0000);

        // Word store at offset 0
        issue(1'b1, 32'hC000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF);
        step();
        cpu_req = 1'b0;
        check("ws_mode", {29'b0, bus_mode}, 32'b111);
        check("ws_dat", bus_dat_o, 32'hDEAD_BEEF);
        check("ws_num", {28'b0, bus_num}, 32'hC);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        check("ws_done", {31'b0, cpu_done}, 32'd1);
        step();

        // Half loads, signed and unsigned
        load1(32'h1000_0002, 2'd1, 1'b0, 32'h8001_1234);
        check("lh_done", {31'b0, cpu_done}, 32'd1);
        check("lh_rdata", cpu_rdata, 32'hFFFF_8001);
        check("lh_mode", {29'b0, bus_mode}, 32'b011);
        check("lh_wen", {31'b0, bus_wen}, 32'd0);
        step();
        load1(32'h1000_0002, 2'd1, 1'b1, 32'h8001_1234);
        check("lhu_rdata", cpu_rdata, 32'h0000_8001);
        step();
        load1(32'h1000_0003, 2'd0, 1'b0, 32'h8001_1234);
        check("lb3_rdata", cpu_rdata, 32'hFFFF_FF80);
        step();
        load1(32'h1000_0001, 2'd0, 1'b0, 32'h8001_1234);
        check("lb1_rdata", cpu_rdata, 32'h0000_0012);
        step();
        load1(32'h1000_0000, 2'd2, 1'b0, 32'h8001_1234);
        check("lw_rdata", cpu_rdata, 32'h8001_1234);
        step();

        // Timeout of 4 cycles with bus_ready held low
        issue(1'b0, 32'h2000_0000, 2'd2, 1'b0, 32'h0);
        step();
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_req_%0d", i), {31'b0, bus_req}, 32'd1);
            check($sformatf("to_done_%0d", i), {31'b0, cpu_done}, 32'd0);
            step();
        end
        check("to_req_low", {31'b0, bus_req}, 32'd0);
        check("to_done", {31'b0, cpu_done}, 32'd1);
        check("to_err", {31'b0, cpu_err}, 32'd1);
        check("to_rdata", cpu_rdata, 32'd0);
        step();

        // Misaligned word: no bus access, error completion at cycle 1
        load1(32'h1000_0000, 2'd2, 1'b0, 32'h5555_AAAA);
        step();
        issue(1'b0, 32'h1000_0001, 2'd2, 1'b0, 32'h0);
        step();
        cpu_req = 1'b0;
        check("mis_req", {31'b0, bus_req}, 32'd0);
        check("mis_done", {31'b0, cpu_done}, 32'd1);
        check("mis_err", {31'b0, cpu_err}, 32'd1);
        check("mis_rdata", cpu_rdata, 32'd0);
        step();
        check("mis_req_after", {31'b0, bus_req}, 32'd0);
        check("mis_done_after", {31'b0, cpu_done}, 32'd0);

        // Illegal size 3
        issue(1'b0, 32'h1000_0000, 2'd3, 1'b0, 32'h0);
        step();
        cpu_req = 1'b0;
        check("sz3_req", {31'b0, bus_req}, 32'd0);
        check("sz3_err", {31'b0, cpu_err}, 32'd1);
        step();

        // Back-to-back with bus_ready tied high: accept every 3 cycles
        issue(1'b0, 32'h4000_0000, 2'd2, 1'b0, 32'h0);
        bus_ready = 1'b1;
        bus_dat_i = 32'h0123_4567;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("b2b_ready_%0d", i), {31'b0, cpu_ready}, (i % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("b2b_req_%0d", i), {31'b0, bus_req}, (i % 3 == 1) ? 32'd1 : 32'd0);
            check($sformatf("b2b_done_%0d", i), {31'b0, cpu_done}, (i % 3 == 2) ? 32'd1 : 32'd0);
            step();
        end
        cpu_req = 1'b0;
        bus_ready = 1'b0;
        check("b2b_rdata", cpu_rdata, 32'h0123_4567);

        // Request held only while busy is not queued
        issue(1'b1, 32'h5000_0000, 2'd2, 1'b0, 32'h1111_2222);
        step();
        issue(1'b1, 32'h6000_0004, 2'd2, 1'b0, 32'h3333_4444);
        bus_ready = 1'b1;
        step();
        cpu_req = 1'b0;
        bus_ready = 1'b0;
        check("nq_done", {31'b0, cpu_done}, 32'd1);
        step();
        step();
        check("nq_req", {31'b0, bus_req}, 32'd0);
        check("nq_num", {28'b0, bus_num}, 32'h5);

        // Reset asserted while in BUS
        issue(1'b1, 32'h7000_0005, 2'd0, 1'b0, 32'h0000_00CD);
        step();
        cpu_req = 1'b0;
        check("rb_req_before", {31'b0, bus_req}, 32'd1);
        rst_n = 1'b0;
        step();
        check("rb_req", {31'b0, bus_req}, 32'd0);
        check("rb_done", {31'b0, cpu_done}, 32'd0);
        check("rb_wen", {31'b0, bus_wen}, 32'd0);
        check("rb_mode", {29'b0, bus_mode}, 32'd0);
        check("rb_addr", {4'b0, bus_addr}, 32'd0);
        check("rb_num", {28'b0, bus_num}, 32'd0);
        check("rb_dat", bus_dat_o, 32'd0);
        check("rb_rdata", cpu_rdata, 32'd0);
        check("rb_err", {31'b0, cpu_err}, 32'd0);
        rst_n = 1'b1;
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        check("rb_no_done", {31'b0, cpu_done}, 32'd0);
        check("rb_ready", {31'b0, cpu_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
